reg_read_fifo: RTL
==================

Name: reg_read_fifo

Overview:
- Reader-side buffer for the 8-bit datapath registers. A producer writes words with a `Load` strobe; this block queues them in a small FIFO.
- A consumer drains the FIFO with a `Read` strobe and receives each word on a registered output with a one-cycle valid pulse.
- It decouples a loading stage from an unloading stage on the single datapath clock. It also reports occupancy and sticky overflow/underflow errors.

Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 4, number of FIFO entries; must be a power of two, at least 2
- ADDR_W, 2, pointer width; equals log2(DEPTH)

Ports:
- Clock  input  1  single system clock; all state changes on its rising edge
- Clear  input  1  synchronous, active-high reset; highest priority
- Load  input  1  write strobe; pushes inData when accepted
- inData  input  WIDTH  word to push
- Read  input  1  read strobe; pops the head word when accepted
- outData  output  WIDTH  registered popped word; holds its value between pops
- OutValid  output  1  high for exactly one cycle after an accepted pop
- Empty  output  1  high when Count == 0
- Full  output  1  high when Count == DEPTH
- Count  output  ADDR_W+1  number of stored words, 0..DEPTH
- Overflow  output  1  sticky; set on a rejected Load
- Underflow  output  1  sticky; set on a rejected Read

Behaviour:
- Reset: Clear sampled high at a rising edge sets the following, with no other action that cycle regardless of Load/Read:
  - write pointer = 0, read pointer = 0, Count = 0
  - outData = 0, OutValid = 0, Overflow = 0, Underflow = 0
  - Empty = 1, Full = 0 (both derived from Count)
  - Clear mid-operation discards all stored words. Memory contents need not be cleared.
- Write acceptance: `wr_ok = Load & (~Full | Read)`.
  - On wr_ok: the memory entry at the write pointer takes inData, and the write pointer increments modulo DEPTH (wraps from DEPTH-1 to 0).
- Read acceptance: `rd_ok = Read & ~Empty`.
  - On rd_ok: outData takes the entry at the read pointer, the read pointer increments modulo DEPTH, and OutValid = 1 next cycle.
  - Otherwise OutValid = 0 and outData holds.
- Latency: a word written at edge N can be popped by a Read sampled at edge N+1 at the earliest. It appears on outData after that edge. There is no write-to-read bypass.
- Count update:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged on both or neither
- Simultaneous Load and Read:
  - Full: both accepted, Count stays DEPTH, Overflow not set.
  - Empty: Load accepted, Read rejected (Underflow set), Count becomes 1.
  - Otherwise: both accepted, Count unchanged.
- Overflow = 1 from the next edge when Load & Full & ~Read. The word is dropped and state is unchanged.
- Underflow = 1 from the next edge when Read & Empty. outData holds and OutValid = 0.
- Both error flags stay set until Clear.
- Empty, Full and Count are registered-state-derived. They reflect the state after the most recent edge, with no combinational path from Load/Read.

Test Plan:
- Clear=1 for one edge with Load=1, inData=8'd5 → after the edge: Count=0, Empty=1, outData=0, OutValid=0, no word stored.
- Load 8'd10, 8'd20, 8'd30 on three edges, then Read on three edges → outData 10, 20, 30 in order, each with a one-cycle OutValid pulse; finally Count=0, Empty=1.
- Load 8'd1..8'd4 (Full=1, Count=4), then Load 8'd9 with Read=0 → Overflow=1, Count=4; draining yields 1, 2, 3, 4 with 9 absent.
- Full with Load=1, inData=8'd7, Read=1 on the same edge → outData=1, Count stays 4; further reads give 2, 3, 4, 7. Overflow stays 0.
- Empty with Read=1 → Underflow=1, OutValid=0, outData holds its prior value.
- Empty with Load=1 (8'd42) and Read=1 on the same edge → Count=1, Underflow=1; next Read gives outData=42.
- Wrap-around: push and pop 10 words 8'd100..8'd109, interleaved with occupancy never exceeding 3 → output order intact across pointer wrap. Clear asserted mid-stream → Count=0 and previously stored words never appear.

Source files
------------

// File: rtl/reg_read_fifo_if.sv
// reg_read_fifo_if: load/read handshake, data and status bundle for reg_read_fifo
interface reg_read_fifo_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              Load;
  logic [WIDTH-1:0]  inData;
  logic              Read;
  logic [WIDTH-1:0]  outData;
  logic              OutValid;
  logic              Empty;
  logic              Full;
  logic [ADDR_W:0]   Count;
  logic              Overflow;
  logic              Underflow;
  modport master (
    output Load, inData, Read,
    input  outData, OutValid, Empty, Full, Count, Overflow, Underflow
  );
  modport slave (
    input  Load, inData, Read,
    output outData, OutValid, Empty, Full, Count, Overflow, Underflow
  );
endinterface

// File: rtl/reg_read_fifo.sv
// reg_read_fifo: small FIFO with registered pop output, occupancy and sticky error flags
module reg_read_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input logic           Clock,
  input logic           Clear,
  reg_read_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic              full, empty, wr_ok, rd_ok;
  assign full  = count_q == FULL_CNT;
  assign empty = count_q == '0;
  // a pop frees a slot in the same edge, so a full FIFO still accepts a load alongside a read
  assign wr_ok = bus.Load & (~full | bus.Read);
  assign rd_ok = bus.Read & ~empty;
  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (wr_ok & ~rd_ok) ? count_q + 1'b1 : (rd_ok & ~wr_ok) ? count_q - 1'b1 : count_q;
    out_d    = rd_ok ? mem_q[rd_ptr_q] : out_q;
    valid_d  = rd_ok;
    ovf_d    = ovf_q | (bus.Load & full & ~bus.Read);
    udf_d    = udf_q | (bus.Read & empty);
  end
  always_ff @(posedge Clock) begin
    if (Clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  always_ff @(posedge Clock) begin
    if (!Clear && wr_ok) mem_q[wr_ptr_q] <= bus.inData;
  end
  assign bus.outData   = out_q;
  assign bus.OutValid  = valid_q;
  assign bus.Empty     = empty;
  assign bus.Full      = full;
  assign bus.Count     = count_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = udf_q;
endmodule
